// File: rtl/control_seq.sv
// Multi-cycle control sequencer for the accumulator datapath: decodes TypeBit/OP,
// stretches load/store over MEM_LAT cycles, and tracks halt, illegal ops and retirements.
module control_seq #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             TypeBit,
  input  logic [OP_W-1:0]  OP,
  output logic             RegWrite,
  output logic             AccWrite,
  output logic             Branch,
  output logic             ReadMem,
  output logic             WriteMem,
  output logic             LookUp,
  output logic             of0,
  output logic             isMem,
  output logic             Halt,
  output logic             PCEn,
  output logic             Busy,
  output logic             Done,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [OP_W-1:0] OP_TAKE   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_PUT    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_STORE  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NAND   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHL    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SHR    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_LOOKUP = OP_W'(8);
  localparam logic [OP_W-1:0] OP_LSN    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_EQL    = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(12);
  localparam logic [OP_W-1:0] OP_OF0    = OP_W'(13);
  localparam logic [OP_W-1:0] OP_HALT   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_RSVD   = OP_W'(15);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, HALTED} state_t;

  state_t           state;
  logic [LAT_W-1:0] waitCnt;

  logic isLoad, isStore, retire, goHalt, goWait, markIllegal;

  assign isLoad  = (OP == OP_LOAD);
  assign isStore = (OP == OP_STORE);

  // Control decode; everything outside RUN/MEM_WAIT reads zero
  always_comb begin
    RegWrite    = 1'b0;
    AccWrite    = 1'b0;
    Branch      = 1'b0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    LookUp      = 1'b0;
    of0         = 1'b0;
    isMem       = 1'b0;
    Halt        = 1'b0;
    PCEn        = 1'b0;
    retire      = 1'b0;
    goHalt      = 1'b0;
    goWait      = 1'b0;
    markIllegal = 1'b0;
    case (state)
      RUN: begin
        if (TypeBit) begin
          Branch = 1'b1;
          retire = 1'b1;
        end else if (isLoad || isStore) begin
          ReadMem  = isLoad;
          WriteMem = isStore;
          isMem    = isLoad;
          if (MEM_LAT == 1) begin
            AccWrite = isLoad;
            PCEn     = 1'b1;
            retire   = 1'b1;
          end else begin
            goWait = 1'b1;
          end
        end else begin
          PCEn   = 1'b1;
          retire = 1'b1;
          case (OP)
            OP_TAKE, OP_XOR, OP_NAND, OP_SHL, OP_SHR,
            OP_LSN, OP_EQL, OP_ADD, OP_SUB: AccWrite = 1'b1;
            OP_PUT:    RegWrite = 1'b1;
            OP_LOOKUP: begin
              LookUp   = 1'b1;
              AccWrite = 1'b1;
            end
            OP_OF0:    of0 = 1'b1;
            OP_HALT: begin
              Halt   = 1'b1;
              PCEn   = 1'b0;
              goHalt = 1'b1;
            end
            default:   markIllegal = (OP >= OP_RSVD);
          endcase
        end
      end
      MEM_WAIT: begin
        ReadMem  = isLoad;
        WriteMem = isStore;
        isMem    = isLoad;
        if (waitCnt == LAT_W'(1)) begin
          AccWrite = isLoad;
          PCEn     = 1'b1;
          retire   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State, status flags and saturating retire counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      waitCnt    <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      IllegalOp  <= 1'b0;
      InstrCount <= '0;
    end else begin
      if (retire && (InstrCount != {CNT_W{1'b1}}))
        InstrCount <= InstrCount + CNT_W'(1);
      if (markIllegal)
        IllegalOp <= 1'b1;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= RUN;
            Busy  <= 1'b1;
          end
        end
        RUN: begin
          if (goHalt) begin
            state <= HALTED;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else if (goWait) begin
            state   <= MEM_WAIT;
            waitCnt <= LAT_W'(MEM_LAT - 1);
          end
        end
        MEM_WAIT: begin
          waitCnt <= waitCnt - LAT_W'(1);
          if (waitCnt == LAT_W'(1))
            state <= RUN;
        end
        HALTED: begin
          if (Start) begin
            state      <= RUN;
            Busy       <= 1'b1;
            Done       <= 1'b0;
            IllegalOp  <= 1'b0;
            InstrCount <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Multi-cycle control sequencer for the accumulator datapath.
- Decodes TypeBit/OP with the same opcode map as the single-cycle decoder: 0 take, 1 put, 2 load, 3 store, 4 xor, 5 nand, 6 shl, 7 shr, 8 lookup, 9 lsn, 10 eql, 11 add, 12 sub, 13 of0, 14 halt, >=15 reserved.
- Adds start/halt/run state, parametrised memory latency, explicit PC-advance, a sticky illegal-op flag and a retired-instruction counter.
- Sits between instruction ROM/IR and datapath/PC unit; replaces the combinational decoder.

Parameters:
- OP_W, 4, opcode width; must be >=4; encodings >=15 reserved.
- MEM_LAT, 2, total cycles a load/store occupies; must be >=1.
- CNT_W, 16, width of InstrCount.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- Start  in  1  level; begins/restarts execution.
- TypeBit  in  1  1 = branch-format instruction.
- OP  in  OP_W  opcode of current instruction (stable while Busy).
- RegWrite, AccWrite, Branch, ReadMem, WriteMem, LookUp, of0, isMem, Halt  out  1 each  datapath controls; meaning unchanged from single-cycle decoder.
- PCEn  out  1  advance PC by one this cycle.
- Busy  out  1  registered; high in RUN/MEM_WAIT.
- Done  out  1  registered; high in HALTED.
- IllegalOp  out  1  registered, sticky; reserved opcode executed.
- InstrCount  out  CNT_W  registered; retired instructions, saturating.

Behaviour:
- States: IDLE, RUN, MEM_WAIT, HALTED.
- Reset (async, Reset_n=0): state=IDLE, Busy=Done=IllegalOp=0, InstrCount=0, MEM_WAIT counter=0.
- Control outputs are combinational from state+TypeBit+OP, so all read 0 immediately on reset assertion.
- IDLE: all control outputs 0. Start=1 -> RUN next edge; Busy=1 from that edge.
- RUN, TypeBit=1: Branch=1, all others 0, PCEn=0 (PC unit loads target). Retires; stays RUN.
- RUN, OP in {0,1,4..13}: decoder table values; PCEn=1. Retires; stays RUN.
- RUN, OP 2/3 (load/store): ReadMem=1 (load) or WriteMem=1 (store).
  - isMem=1 for load only.
  - MEM_LAT=1: AccWrite=1 (load), PCEn=1, retires, stays RUN.
  - MEM_LAT>1: PCEn=0, AccWrite=0; counter loads MEM_LAT-1; -> MEM_WAIT.
- MEM_WAIT: ReadMem/WriteMem/isMem held as in RUN; counter decrements each edge.
  - Final cycle (counter==1): AccWrite=1 for load, PCEn=1, retires, -> RUN.
  - Total occupancy exactly MEM_LAT cycles.
- RUN, OP 14: Halt=1 for one cycle, PCEn=0. Retires; -> HALTED (Busy=0, Done=1).
- RUN, OP >=15: all controls 0, PCEn=1 (skip). Retires; IllegalOp<=1 (sticky).
- HALTED: all controls 0; Done=1.
  - Start=1 -> RUN; InstrCount<=0, IllegalOp<=0, Done<=0.
- Start ignored in RUN/MEM_WAIT.
- Retire = exactly one InstrCount increment per instruction, on its final cycle. Saturates at 2^CNT_W-1 (no wrap).
- TypeBit=1 has priority over OP in every RUN cycle.
- Reset mid-MEM_WAIT aborts the access: no AccWrite, no PCEn, no count.

Test Plan:
- Reset, Start=1 one cycle, OP=11 x3 then OP=14 -> Busy next edge; AccWrite=1,PCEn=1 each add; Halt=1 one cycle; Done=1; InstrCount=4.
- MEM_LAT=3, OP=2 -> ReadMem=isMem=1 for 3 cycles; AccWrite=PCEn=1 only on 3rd; InstrCount+1. Repeat with OP=3 -> WriteMem 3 cycles, AccWrite never.
- MEM_LAT=1, OP=2 -> ReadMem=AccWrite=PCEn=1 same cycle, no MEM_WAIT.
- TypeBit=1 with OP=14 -> Branch=1, Halt=0, PCEn=0, stays RUN.
- OP=15 -> controls 0, PCEn=1, IllegalOp=1 and stays 1; halt then Start -> IllegalOp=0, InstrCount=0.
- CNT_W=3, 9 retired instructions -> InstrCount stops at 7. Separately, Reset_n low during MEM_WAIT -> all outputs 0 at once, IDLE.
